mem_stage: RTL

Memory-access stage of the RV32I pipeline, between execute and writeback, and the write/request side of the data-cache interface whose read data writeback consumes. Takes one stage_regs bundle per cycle, issues word-aligned dcache read/write requests with byte enables and replicated store data, and stalls upstream until dcache_resp. Registers the bundle and the raw dcache word into the MEM/WB register; writeback does all load masking.

---
 rtl/rv32i_types.sv | 34 +++
 rtl/store_mask.sv | 36 +++
 rtl/mem_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the memory stage.
//   mem_width_t : access width, encoded as funct3[1:0]
//   ctrl_t      : control bits the memory stage consumes
//   stage_regs  : inter-stage bundle (EX/MEM and MEM/WB)
//   mem_state_t : memory-stage FSM state
package rv32i_types;

  typedef enum logic [1:0] {
    MemByte = 2'b00,
    MemHalf = 2'b01,
    MemWord = 2'b10
  } mem_width_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    mem_width_t load_type;
    logic       load_regfile;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    ctrl_t       ctrl;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rs2;
  } stage_regs;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StReq  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/store_mask.sv
// Store lane steering: byte enables and replicated store data for one access.
//   load_type   in  access width
//   addr        in  low two address bits
//   rs2         in  raw store data
//   byte_enable out byte lanes written
//   wdata       out store data replicated across the word
module store_mask
  import rv32i_types::*;
(
  input  mem_width_t  load_type,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  output logic [3:0]  byte_enable,
  output logic [31:0] wdata
);

  always_comb begin
    byte_enable = 4'b1111;
    wdata       = rs2;
    case (load_type)
      MemByte: begin
        byte_enable = 4'b0001 << addr;
        wdata       = {4{rs2[7:0]}};
      end
      MemHalf: begin
        byte_enable = 4'b0011 << addr;
        wdata       = {2{rs2[15:0]}};
      end
      default: begin
        byte_enable = 4'b1111;
        wdata       = rs2;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues dcache requests, stalls upstream until the
// access completes, and registers the bundle plus raw read word for writeback.
//   clk, rst            clock; synchronous active-high reset
//   regs_in             EX/MEM bundle (held by stall_out)
//   dcache_resp/rdata   access complete / read word
//   dcache_*            registered request outputs
//   stall_out           hold upstream stages
//   regs_out, dcache_out, misaligned  registered MEM/WB outputs
module mem_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  stage_regs   regs_in,
  input  logic        dcache_resp,
  input  logic [31:0] dcache_rdata,
  output logic        dcache_read,
  output logic        dcache_write,
  output logic [31:0] dcache_address,
  output logic [31:0] dcache_wdata,
  output logic [3:0]  dcache_byte_enable,
  output logic        stall_out,
  output stage_regs   regs_out,
  output logic [31:0] dcache_out,
  output logic        misaligned
);

  mem_state_t  state_q, state_d;
  logic        read_q, write_q;
  logic [31:0] addr_q, wdata_q, dout_q;
  logic [3:0]  be_q;
  stage_regs   regs_q, pass_c;
  logic        mis_q;

  logic        mem_op, mis_c, issue;
  logic [3:0]  sm_be;
  logic [31:0] sm_wdata;

  store_mask u_store_mask (
    .load_type   (regs_in.ctrl.load_type),
    .addr        (regs_in.alu[1:0]),
    .rs2         (regs_in.rs2),
    .byte_enable (sm_be),
    .wdata       (sm_wdata)
  );

  always_comb begin
    mem_op = regs_in.ctrl.mem_read | regs_in.ctrl.mem_write;
    case (regs_in.ctrl.load_type)
      MemByte: mis_c = 1'b0;
      MemHalf: mis_c = mem_op & regs_in.alu[0];
      default: mis_c = mem_op & (regs_in.alu[1:0] != 2'b00);
    endcase
    issue = mem_op & ~mis_c;

    // Misaligned accesses flow through but must never write the register file.
    pass_c = regs_in;
    if (mis_c) pass_c.ctrl.load_regfile = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    stall_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d   = StReq;
          stall_out = 1'b1;
        end
      end
      StReq: begin
        // Release upstream in the resp cycle so the next bundle lands at the
        // same edge this one retires.
        stall_out = ~dcache_resp;
        if (dcache_resp) state_d = StIdle;
      end
    endcase
    if (rst) stall_out = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      regs_q  <= '0;
      dout_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            // Write wins when both mem_read and mem_write are set.
            read_q  <= ~regs_in.ctrl.mem_write;
            write_q <= regs_in.ctrl.mem_write;
            addr_q  <= {regs_in.alu[31:2], 2'b00};
            wdata_q <= sm_wdata;
            be_q    <= regs_in.ctrl.mem_write ? sm_be : 4'b1111;
            regs_q  <= '0;
            mis_q   <= 1'b0;
          end else begin
            regs_q <= pass_c;
            mis_q  <= mis_c;
          end
        end
        StReq: begin
          if (dcache_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            regs_q  <= regs_in;
            mis_q   <= 1'b0;
            if (read_q) dout_q <= dcache_rdata;
          end else begin
            regs_q <= '0;
          end
        end
      endcase
    end
  end

  assign dcache_read        = read_q;
  assign dcache_write       = write_q;
  assign dcache_address     = addr_q;
  assign dcache_wdata       = wdata_q;
  assign dcache_byte_enable = be_q;
  assign regs_out           = regs_q;
  assign dcache_out         = dout_q;
  assign misaligned         = mis_q;

endmodule
